dram_arb_cpu: RTL and testbench

- Per-DRAM-cycle arbiter between the memory manager's CPU request port, the video fetcher and DRAM refresh. It sits directly downstream of the Z80 memory manager.
- Consumes cpu_req/cpu_addr/cpu_wrbsel; produces cpu_next/cpu_strobe/cpu_latch/cpu_rddata.
- Issues one command per 4-clock DRAM cycle (c0..c3) to the DRAM controller and routes returned read data back to the winning requestor.

---
 rtl/dram_arb_cpu.sv | 203 ++++++++++++++++++++
 tb/tb_dram_arb_cpu.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arb_cpu.sv
// Per-DRAM-cycle arbiter between the CPU port, the video fetcher and refresh.
// One command per 4-clock cycle is decided at c3, issued at c0, and read data is routed back to its owner.
module dram_arb_cpu #(
  parameter int REF_PERIOD  = 54,
  parameter int REF_MAXWAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic        cpu_wrbsel,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic        cpu_latch,
  output logic [15:0] cpu_rddata,
  input  logic        vid_req,
  input  logic [20:0] vid_addr,
  output logic        vid_strobe,
  output logic [15:0] vid_rddata,
  output logic        dram_go,
  output logic        dram_ref,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [1:0]  dram_bsel,
  output logic [15:0] dram_wrdata,
  input  logic        dram_rrdy,
  input  logic [15:0] dram_rddata
);

  localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int WW = (REF_MAXWAIT > 0) ? $clog2(REF_MAXWAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(REF_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(REF_MAXWAIT);
  localparam logic [WW-1:0] WAIT_ZERO  = WW'(0);
  localparam logic [WW-1:0] WAIT_ONE   = WW'(1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_VID  = 2'd2,
    OWN_REF  = 2'd3
  } owner_t;

  owner_t        owner_r;
  owner_t        grant_s;
  logic          arb_s;
  logic          ref_force_s;
  logic          cpu_hit_s;
  logic          vid_hit_s;
  logic [CW-1:0] ref_cnt_r;
  logic          ref_pend_r;
  logic [WW-1:0] ref_wait_r;
  logic [15:0]   cpu_data_r;
  logic [15:0]   vid_data_r;

  // A decision slot needs a clean one-hot c3; a corrupted phase set never grants.
  assign arb_s       = c3 & ~c0 & ~c1 & ~c2;
  assign ref_force_s = ref_pend_r && (ref_wait_r == WAIT_MAX);
  assign cpu_next    = !vid_req && !ref_force_s;

  // Next owner: video, forced refresh, CPU, pending refresh, idle.
  always_comb begin
    grant_s = OWN_IDLE;
    if (vid_req) begin
      grant_s = OWN_VID;
    end else if (ref_force_s) begin
      grant_s = OWN_REF;
    end else if (cpu_req) begin
      grant_s = OWN_CPU;
    end else if (ref_pend_r) begin
      grant_s = OWN_REF;
    end else begin
      grant_s = OWN_IDLE;
    end
  end

  // Owner of the current DRAM cycle, updated at each decision slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_IDLE;
    end else if (arb_s) begin
      owner_r <= grant_s;
    end else begin
      owner_r <= owner_r;
    end
  end

  // Command registers toward the DRAM controller; dram_go/dram_ref pulse for the c0 clock only.
  always_ff @(posedge clk) begin
    if (rst) begin
      dram_go     <= 1'b0;
      dram_ref    <= 1'b0;
      dram_rnw    <= 1'b0;
      dram_addr   <= 21'd0;
      dram_bsel   <= 2'b00;
      dram_wrdata <= 16'd0;
    end else begin
      dram_go  <= arb_s && (grant_s != OWN_IDLE);
      dram_ref <= arb_s && (grant_s == OWN_REF);
      if (arb_s) begin
        case (grant_s)
          OWN_CPU: begin
            dram_rnw    <= cpu_rnw;
            dram_addr   <= cpu_addr;
            dram_wrdata <= {cpu_wrdata, cpu_wrdata};
            if (cpu_rnw) begin
              dram_bsel <= 2'b11;
            end else begin
              dram_bsel <= cpu_wrbsel ? 2'b10 : 2'b01;
            end
          end
          OWN_VID: begin
            dram_rnw  <= 1'b1;
            dram_addr <= vid_addr;
            dram_bsel <= 2'b11;
          end
          OWN_REF: begin
            dram_rnw <= 1'b1;
          end
          default: begin
            dram_rnw <= dram_rnw;
          end
        endcase
      end
    end
  end

  // Refresh timer; a fresh expiry outranks a same-slot grant so the request is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_r  <= CNT_RELOAD;
      ref_pend_r <= 1'b0;
      ref_wait_r <= WAIT_ZERO;
    end else if (arb_s) begin
      if (ref_cnt_r == CNT_ZERO) begin
        ref_cnt_r  <= CNT_RELOAD;
        ref_pend_r <= 1'b1;
      end else begin
        ref_cnt_r  <= ref_cnt_r - CNT_ONE;
        ref_pend_r <= (grant_s == OWN_REF) ? 1'b0 : ref_pend_r;
      end
      if (grant_s == OWN_REF) begin
        ref_wait_r <= WAIT_ZERO;
      end else if (ref_pend_r && (ref_wait_r != WAIT_MAX)) begin
        ref_wait_r <= ref_wait_r + WAIT_ONE;
      end else begin
        ref_wait_r <= ref_wait_r;
      end
    end
  end

  // Route a returning read to its owner; writes, refresh and idle cycles drop it.
  always_comb begin
    cpu_hit_s = 1'b0;
    vid_hit_s = 1'b0;
    if (!rst && dram_rrdy) begin
      case (owner_r)
        OWN_CPU: cpu_hit_s = dram_rnw;
        OWN_VID: vid_hit_s = 1'b1;
        default: begin
          cpu_hit_s = 1'b0;
          vid_hit_s = 1'b0;
        end
      endcase
    end else begin
      cpu_hit_s = 1'b0;
      vid_hit_s = 1'b0;
    end
  end

  assign cpu_strobe = cpu_hit_s;
  assign vid_strobe = vid_hit_s;
  assign cpu_rddata = cpu_hit_s ? dram_rddata : cpu_data_r;
  assign vid_rddata = vid_hit_s ? dram_rddata : vid_data_r;

  // Hold captured read words and stretch cpu_latch up to the next decision slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_data_r <= 16'd0;
      vid_data_r <= 16'd0;
      cpu_latch  <= 1'b0;
    end else begin
      cpu_data_r <= cpu_hit_s ? dram_rddata : cpu_data_r;
      vid_data_r <= vid_hit_s ? dram_rddata : vid_data_r;
      if (cpu_hit_s) begin
        cpu_latch <= 1'b1;
      end else if (arb_s) begin
        cpu_latch <= 1'b0;
      end else begin
        cpu_latch <= cpu_latch;
      end
    end
  end

endmodule

// File: tb/tb_dram_arb_cpu.sv
// Directed bench for dram_arb_cpu with REF_PERIOD=4 and REF_MAXWAIT=2.
// Stimulus changes 1 time unit after each rising edge; checks follow 1 unit later.
module tb_dram_arb_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ph  = 2'd0;
  logic        c0, c1, c2, c3;
  logic        cpu_req = 1'b0;
  logic        cpu_rnw = 1'b0;
  logic [20:0] cpu_addr = 21'd0;
  logic        cpu_wrbsel = 1'b0;
  logic [7:0]  cpu_wrdata = 8'd0;
  logic        vid_req = 1'b0;
  logic [20:0] vid_addr = 21'd0;
  logic        dram_rrdy = 1'b0;
  logic [15:0] dram_rddata = 16'd0;
  logic        cpu_next, cpu_strobe, cpu_latch, vid_strobe;
  logic [15:0] cpu_rddata, vid_rddata, dram_wrdata;
  logic        dram_go, dram_ref, dram_rnw;
  logic [20:0] dram_addr;
  logic [1:0]  dram_bsel;
  int          nvec = 0;
  int          nerr = 0;

  assign c0 = (ph == 2'd0);
  assign c1 = (ph == 2'd1);
  assign c2 = (ph == 2'd2);
  assign c3 = (ph == 2'd3);

  dram_arb_cpu #(.REF_PERIOD(4), .REF_MAXWAIT(2)) dut (
    .clk(clk), .rst(rst), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
    .cpu_wrbsel(cpu_wrbsel), .cpu_wrdata(cpu_wrdata),
    .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_latch(cpu_latch),
    .cpu_rddata(cpu_rddata), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_strobe(vid_strobe), .vid_rddata(vid_rddata),
    .dram_go(dram_go), .dram_ref(dram_ref), .dram_rnw(dram_rnw),
    .dram_addr(dram_addr), .dram_bsel(dram_bsel), .dram_wrdata(dram_wrdata),
    .dram_rrdy(dram_rrdy), .dram_rddata(dram_rddata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ph <= ph + 2'd1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n;
    n = 0;
    while (ph != p && n < 8) begin
      cyc();
      n++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    chk("rst_go",     32'(dram_go),     32'd0);
    chk("rst_ref",    32'(dram_ref),    32'd0);
    chk("rst_rnw",    32'(dram_rnw),    32'd0);
    chk("rst_addr",   32'(dram_addr),   32'd0);
    chk("rst_bsel",   32'(dram_bsel),   32'd0);
    chk("rst_wrdata", 32'(dram_wrdata), 32'd0);
    chk("rst_cstb",   32'(cpu_strobe),  32'd0);
    chk("rst_latch",  32'(cpu_latch),   32'd0);
    chk("rst_crd",    32'(cpu_rddata),  32'd0);
    chk("rst_vstb",   32'(vid_strobe),  32'd0);
    chk("rst_vrd",    32'(vid_rddata),  32'd0);
    chk("rst_next",   32'(cpu_next),    32'd1);

    // Idle CPU read
    wait_phase(2'd3);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h0ABCD;
    #1;
    chk("rd_next", 32'(cpu_next), 32'd1);
    cyc();
    cpu_req = 1'b0;
    chk("rd_go",   32'(dram_go),   32'd1);
    chk("rd_addr", 32'(dram_addr), 32'h0ABCD);
    chk("rd_bsel", 32'(dram_bsel), 32'h3);
    chk("rd_rnw",  32'(dram_rnw),  32'd1);
    chk("rd_ref",  32'(dram_ref),  32'd0);
    cyc();
    chk("rd_go_c1", 32'(dram_go), 32'd0);
    cyc();
    dram_rrdy = 1'b1; dram_rddata = 16'h1234;
    #1;
    chk("rd_stb",      32'(cpu_strobe), 32'd1);
    chk("rd_data",     32'(cpu_rddata), 32'h1234);
    chk("rd_latch_c2", 32'(cpu_latch),  32'd0);
    chk("rd_vstb",     32'(vid_strobe), 32'd0);
    cyc();
    dram_rrdy = 1'b0; dram_rddata = 16'h0000;
    #1;
    chk("rd_stb_off",  32'(cpu_strobe), 32'd0);
    chk("rd_latch_c3", 32'(cpu_latch),  32'd1);
    chk("rd_hold_c3",  32'(cpu_rddata), 32'h1234);
    cyc();
    chk("rd_latch_c0", 32'(cpu_latch),  32'd0);
    chk("rd_hold_c0",  32'(cpu_rddata), 32'h1234);
    chk("idle_go",     32'(dram_go),    32'd0);

    // CPU write, high byte
    wait_phase(2'd3);
    cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_wrbsel = 1'b1; cpu_wrdata = 8'h5A;
    cyc();
    cpu_req = 1'b0;
    chk("wr_go",     32'(dram_go),     32'd1);
    chk("wr_rnw",    32'(dram_rnw),    32'd0);
    chk("wr_wrdata", 32'(dram_wrdata), 32'h5A5A);
    chk("wr_bsel",   32'(dram_bsel),   32'h2);
    chk("wr_addr",   32'(dram_addr),   32'h0ABCD);
    cyc();
    cyc();
    dram_rrdy = 1'b1; dram_rddata = 16'hBEEF;
    #1;
    chk("wr_nostb",  32'(cpu_strobe), 32'd0);
    chk("wr_rdhold", 32'(cpu_rddata), 32'h1234);
    cyc();
    dram_rrdy = 1'b0;
    #1;
    chk("wr_nolatch", 32'(cpu_latch), 32'd0);

    // Video and CPU contend on the same c3
    do_reset();
    wait_phase(2'd3);
    vid_req = 1'b1; vid_addr = 21'h1F0F0;
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h00123;
    #1;
    chk("ct_next", 32'(cpu_next), 32'd0);
    cyc();
    vid_req = 1'b0;
    #1;
    chk("ct_go",      32'(dram_go),   32'd1);
    chk("ct_vaddr",   32'(dram_addr), 32'h1F0F0);
    chk("ct_vbsel",   32'(dram_bsel), 32'h3);
    chk("ct_next_c0", 32'(cpu_next),  32'd1);
    cyc();
    cyc();
    dram_rrdy = 1'b1; dram_rddata = 16'hCAFE;
    #1;
    chk("ct_vstb",  32'(vid_strobe), 32'd1);
    chk("ct_vdata", 32'(vid_rddata), 32'hCAFE);
    chk("ct_cstb",  32'(cpu_strobe), 32'd0);
    cyc();
    dram_rrdy = 1'b0;
    #1;
    chk("ct_vstb_off", 32'(vid_strobe), 32'd0);
    cyc();
    cpu_req = 1'b0;
    chk("ct_cpu_go",   32'(dram_go),   32'd1);
    chk("ct_cpu_addr", 32'(dram_addr), 32'h00123);
    cyc();
    cyc();
    dram_rrdy = 1'b1; dram_rddata = 16'h0F0F;
    #1;
    chk("ct_cstb2",  32'(cpu_strobe), 32'd1);
    chk("ct_cdata2", 32'(cpu_rddata), 32'h0F0F);
    chk("ct_vhold",  32'(vid_rddata), 32'hCAFE);
    chk("ct_vstb2",  32'(vid_strobe), 32'd0);
    cyc();
    dram_rrdy = 1'b0;

    // Reset in the middle of a CPU read
    wait_phase(2'd3);
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h00042;
    cyc();
    cpu_req = 1'b0;
    chk("mr_go",   32'(dram_go),   32'd1);
    chk("mr_addr", 32'(dram_addr), 32'h00042);
    cyc();
    rst = 1'b1;
    cyc();
    dram_rrdy = 1'b1; dram_rddata = 16'h9999;
    #1;
    chk("mr_nostb", 32'(cpu_strobe), 32'd0);
    cyc();
    rst = 1'b0; dram_rrdy = 1'b0;
    #1;
    chk("mr_go0",    32'(dram_go),     32'd0);
    chk("mr_addr0",  32'(dram_addr),   32'd0);
    chk("mr_bsel0",  32'(dram_bsel),   32'd0);
    chk("mr_rnw0",   32'(dram_rnw),    32'd0);
    chk("mr_wrd0",   32'(dram_wrdata), 32'd0);
    chk("mr_crd0",   32'(cpu_rddata),  32'd0);
    chk("mr_vrd0",   32'(vid_rddata),  32'd0);
    chk("mr_latch0", 32'(cpu_latch),   32'd0);
    // Reloaded timer: first refresh goes out after the 5th slot
    for (int i = 1; i <= 5; i++) begin
      wait_phase(2'd3);
      cyc();
      chk("mr_reload_go",  32'(dram_go),  32'(i == 5));
      chk("mr_reload_ref", 32'(dram_ref), 32'(i == 5));
    end

    // Refresh deferral under a continuous CPU request
    do_reset();
    cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 21'h00777;
    for (int i = 1; i <= 8; i++) begin
      wait_phase(2'd3);
      #1;
      chk("df_next", 32'(cpu_next), 32'(i != 7));
      cyc();
      chk("df_go",  32'(dram_go),  32'd1);
      chk("df_ref", 32'(dram_ref), 32'(i == 7));
      if (i == 7) begin
        cyc();
        chk("df_ref_pulse", 32'(dram_ref), 32'd0);
      end
    end

    // Refresh starved by video, then served ahead of the CPU
    do_reset();
    vid_req = 1'b1; vid_addr = 21'h00500;
    cpu_req = 1'b1; cpu_addr = 21'h00888;
    for (int i = 1; i <= 21; i++) begin
      wait_phase(2'd3);
      if (i == 21) vid_req = 1'b0;
      #1;
      chk("sv_next", 32'(cpu_next), 32'd0);
      cyc();
      chk("sv_go",  32'(dram_go),  32'd1);
      chk("sv_ref", 32'(dram_ref), 32'(i == 21));
    end
    wait_phase(2'd3);
    #1;
    chk("sv_next_after", 32'(cpu_next), 32'd1);
    cyc();
    chk("sv_cpu_go",   32'(dram_go),   32'd1);
    chk("sv_cpu_ref",  32'(dram_ref),  32'd0);
    chk("sv_cpu_addr", 32'(dram_addr), 32'h00888);
    cpu_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
